// File: rtl/cpu_clock_controller_pkg.sv
// Shared encodings for the CPU clock controller: requested modes, controller states,
// and the mapping from a requested mode to the state it selects.
package cpu_clock_controller_pkg;

   localparam logic [1:0] MODE_HALT = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;

   typedef enum logic [1:0] {
      ST_HALTED   = 2'b00,
      ST_RUNNING  = 2'b01,
      ST_STEPPING = 2'b10,
      ST_TRAPPED  = 2'b11
   } cpuState_t;

   // Mode 11 is an alias for HALT.
   function automatic cpuState_t modeTarget(input logic [1:0] mode);
      case (mode)
         MODE_RUN:  return ST_RUNNING;
         MODE_STEP: return ST_STEPPING;
         default:   return ST_HALTED;
      endcase
   endfunction

endpackage

// File: rtl/cpu_clock_controller_step_debouncer.sv
// Step button conditioning: 2-FF synchronizer, then a level that only changes after
// DEBOUNCE_CYCLES consecutive samples disagree with it; Rise pulses one cycle on a 0->1 change.
module step_debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int DB_WIDTH        = 16
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic RawIn,
   output logic Level,
   output logic Rise
);

   localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                sync1;
   logic                sync2;
   logic [DB_WIDTH-1:0] stableCnt;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         stableCnt <= '0;
         Level     <= 1'b0;
         Rise      <= 1'b0;
      end else begin
         sync1 <= RawIn;
         sync2 <= sync1;
         Rise  <= 1'b0;
         // stableCnt counts consecutive samples that disagree with the accepted level
         if (sync2 == Level) begin
            stableCnt <= '0;
         end else if (stableCnt == CNT_LAST) begin
            stableCnt <= '0;
            Level     <= sync2;
            Rise      <= sync2;
         end else begin
            stableCnt <= stableCnt + DB_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/cpu_clock_controller.sv
// Generates the single-cycle CPU enable from the board clock: halt, divided free-run,
// or debounced single-step; CpuEn, CpuClkOut and CycleCount all update from one registered condition.
module cpu_clock_controller
   import cpu_clock_controller_pkg::*;
#(
   parameter int DIV_WIDTH       = 13,
   parameter int DEFAULT_DIV     = 2500,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int DB_WIDTH        = 16
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic [DIV_WIDTH-1:0] DivVal,
   input  logic                 DivLoad,
   input  logic [1:0]           Mode,
   input  logic                 StepBtn,
   input  logic                 HaltReq,
   output logic                 CpuEn,
   output logic                 CpuClkOut,
   output logic [1:0]           State,
   output logic [31:0]          CycleCount
);

   cpuState_t            curState;
   logic [DIV_WIDTH-1:0] divReg;
   logic [DIV_WIDTH-1:0] preCnt;
   logic                 stepLevel;
   logic                 stepRise;
   logic                 tick;
   logic                 stepFire;
   logic                 fire;

   step_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_WIDTH       (DB_WIDTH)
   ) u_stepDebouncer (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .RawIn(StepBtn),
      .Level(stepLevel),
      .Rise (stepRise)
   );

   assign State    = curState;
   assign tick     = (curState == ST_RUNNING) && (preCnt == divReg - DIV_WIDTH'(1));
   assign stepFire = stepRise && stepLevel && (curState == ST_STEPPING);
   assign fire     = (tick || stepFire) && !HaltReq;

   // The divisor register never holds 0, so divReg-1 is always a reachable count.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         divReg <= DIV_WIDTH'(DEFAULT_DIV);
         preCnt <= '0;
      end else if (DivLoad) begin
         divReg <= (DivVal == '0) ? DIV_WIDTH'(1) : DivVal;
         preCnt <= '0;
      end else if (curState != ST_RUNNING || tick) begin
         preCnt <= '0;
      end else begin
         preCnt <= preCnt + DIV_WIDTH'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         curState   <= ST_HALTED;
         CpuEn      <= 1'b0;
         CpuClkOut  <= 1'b0;
         CycleCount <= '0;
      end else begin
         CpuEn <= fire;
         if (fire) begin
            CpuClkOut  <= ~CpuClkOut;
            CycleCount <= CycleCount + 32'd1;
         end
         case (curState)
            ST_TRAPPED: begin
               if (modeTarget(Mode) == ST_HALTED) curState <= ST_HALTED;
            end
            ST_RUNNING, ST_STEPPING: begin
               curState <= HaltReq ? ST_TRAPPED : modeTarget(Mode);
            end
            default: begin
               curState <= modeTarget(Mode);
            end
         endcase
      end
   end

endmodule
